packed_lane_assembler: RTL and testbench
========================================

// Module: packed_lane_assembler
// PURPOSE
//  Upstream producer for the packed-typedef bit-select stage: gathers LANE_W-bit lanes
//  from a valid/ready stream into one packed word typed logic [LANES-1:0][LANE_W-1:0].
//  Holds the finished word for the consumer and exposes the bit at SEL_BIT as out_sel.
//  Default geometry is 3x2 = 6 bits, the [5:0] vector the downstream stage indexes.
// PARAMETERS
//  LANES    3  number of lanes per word (>=2)
//  LANE_W   2  bits per lane (>=1)
//  SEL_BIT  1  flat bit index driven on out_sel (0..LANES*LANE_W-1)
// PORTS
//  clk        in   1              clock; all logic on rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              lane valid
//  in_ready   out  1              lane accepted when in_valid & in_ready
//  in_data    in   LANE_W         lane payload
//  in_last    in   1              frame end; early end pads remaining lanes with 0
//  out_valid  out  1              assembled word available
//  out_ready  in   1              consumer takes word when out_valid & out_ready
//  out_word   out  LANES*LANE_W   packed word; lane k at [k*LANE_W +: LANE_W]
//  out_sel    out  1              out_word[SEL_BIT]
//  out_short  out  1              word closed early by in_last (qualified by out_valid)
// BEHAVIOUR
//  - Reset: state FILL, lane index 0, out_valid=0, out_word=0, out_short=0, in_ready=1.
//  - States: FILL (collecting) and HOLD (word presented). No other states.
//  - FILL: in_ready=1. Accepted lane goes to lane[idx]; idx increments.
//    Word closes on the accept where idx==LANES-1 OR in_last=1; then next cycle HOLD,
//    out_valid=1, idx=0. Unfilled lanes read 0; out_short=1 iff closed with idx<LANES-1.
//    in_last on the final lane is a normal close (out_short=0).
//  - HOLD: out_word/out_sel/out_short stable while out_valid & !out_ready.
//    in_ready = out_ready (pass-through). On out_ready: if in_valid, that lane is
//    written to lane 0 of a fresh word (others cleared), idx=1, state FILL (or straight
//    back to HOLD if LANES close rule fires on that same lane); else FILL, idx=0, word
//    cleared. out_valid drops the cycle after handoff unless a new word closed.
//  - Latency: out_valid rises 1 cycle after the closing lane handshake.
//    Sustained throughput: one word per LANES cycles (no bubble on handoff).
//  - out_sel is combinational from the registered word; no extra latency.
//  - rst mid-frame or mid-HOLD: partial/held word discarded, reset values next cycle.
//  - in_data sampled only on handshake; X on idle in_data must not propagate.
// STRUCTURE
//  - Package packed_asm_pkg: typedef enum logic {FILL, HOLD} asm_state_e;
//    default constants ASM_LANES=3, ASM_LANE_W=2.
//  - Module-local typedefs: lane_t = logic [LANE_W-1:0]; word_t = lane_t [LANES-1:0]
//    (packed multi-dimensional), out_word = flat cast of word_t.
//  - One sub-module: lane_index_counter (clear, inc, wrap-at LANES-1, is_last flag).
// TESTING
//  1 Reset then lanes 2'b01,2'b10,2'b11 back-to-back, out_ready=1 -> out_word=6'b111001,
//    out_sel=0, out_short=0, out_valid one cycle after 3rd accept.
//  2 Lanes 2'b10,2'b00,2'b00 -> out_word=6'b000010, out_sel=1 (the downstream '1').
//  3 Lane 2'b11 with in_last=1 -> out_word=6'b000011, out_short=1, out_sel=1.
//  4 Word held, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_word
//    stable; release out_ready -> handoff and lane 0 of next word captured same cycle.
//  5 Continuous stream of 9 lanes, out_ready=1 -> 3 words, out_valid pulses every
//    3 cycles, no dropped or duplicated lane.
//  6 rst asserted after 2 lanes accepted -> next word built from fresh lanes only;
//    rst during HOLD -> out_valid=0 next cycle, out_word=0.

Source files
------------

// File: rtl/packed_lane_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packed_asm_pkg
//  Description : Shared state encoding and default geometry for the packed
//                lane assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
package packed_asm_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } asm_state_e;

    localparam int ASM_LANES  = 3;
    localparam int ASM_LANE_W = 2;

    function automatic int asm_word_bits(input int lanes, input int lane_w);
        return lanes * lane_w;
    endfunction

endpackage : packed_asm_pkg
`default_nettype wire

// File: rtl/packed_lane_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : packed_lane_assembler_if
//  Description : Lane input stream plus assembled-word output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface packed_lane_assembler_if
    import packed_asm_pkg::*;
#(
    parameter int LANES  = ASM_LANES,
    parameter int LANE_W = ASM_LANE_W
) ();

    logic                                      in_valid;
    logic                                      in_ready;
    logic [LANE_W-1:0]                         in_data;
    logic                                      in_last;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [asm_word_bits(LANES, LANE_W)-1:0]   out_word;
    logic                                      out_sel;
    logic                                      out_short;

    // Producer / consumer environment side.
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_word,
        input  out_sel,
        input  out_short
    );

    // Assembler side.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_word,
        output out_sel,
        output out_short
    );

endinterface : packed_lane_assembler_if
`default_nettype wire

// File: rtl/packed_lane_assembler_lane_index_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_index_counter
//  Description : Lane slot index with clear, increment and wrap at LANES-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_index_counter #(
    parameter int LANES = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_is_last
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx <= '0;
        end else if (i_inc) begin
            if (r_idx == c_LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_idx     = r_idx;
    assign o_is_last = (r_idx == c_LAST_IDX);

endmodule : lane_index_counter
`default_nettype wire

// File: rtl/packed_lane_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : packed_lane_assembler
//  Description : Gathers LANE_W-bit lanes into a packed LANES-lane word and
//                holds it for the consumer; exposes one selected bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module packed_lane_assembler
    import packed_asm_pkg::*;
#(
    parameter int LANES   = ASM_LANES,
    parameter int LANE_W  = ASM_LANE_W,
    parameter int SEL_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    packed_lane_assembler_if.slave bus
);

    localparam int c_WORD_W = LANES * LANE_W;
    localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] word_t;

    asm_state_e         r_state;
    word_t              r_word;
    logic               r_short;

    logic [c_IDX_W-1:0] w_idx;
    logic               w_idx_last;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_close;
    word_t              w_fresh;
    logic [c_WORD_W-1:0] w_flat;

    // In HOLD a lane is only taken when the held word leaves in the same cycle.
    assign w_in_ready = (r_state == FILL) | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    // In HOLD the index is always 0, so only in_last can close a lane taken there.
    assign w_close    = bus.in_last | w_idx_last;

    lane_index_counter #(
        .LANES (LANES),
        .IDX_W (c_IDX_W)
    ) u_lane_index_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept & w_close),
        .i_inc     (w_accept & ~w_close),
        .o_idx     (w_idx),
        .o_is_last (w_idx_last)
    );

    always_comb begin
        w_fresh    = '0;
        w_fresh[0] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_word  <= '0;
            r_short <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_word[w_idx] <= bus.in_data;
                        if (w_close) begin
                            r_state <= HOLD;
                            r_short <= ~w_idx_last;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            r_word  <= w_fresh;
                            r_short <= w_close & ~w_idx_last;
                            r_state <= w_close ? HOLD : FILL;
                        end else begin
                            r_word  <= '0;
                            r_short <= 1'b0;
                            r_state <= FILL;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign w_flat        = r_word;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_word  = w_flat;
    assign bus.out_sel   = w_flat[SEL_BIT];
    assign bus.out_short = r_short;

endmodule : packed_lane_assembler
`default_nettype wire

// File: tb/tb_packed_lane_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packed_lane_assembler
//  Description : Self-checking bench for packed_lane_assembler against a
//                lane-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packed_lane_assembler;

    localparam int LANES   = 3;
    localparam int LANE_W  = 2;
    localparam int SEL_BIT = 1;
    localparam int WORD_W  = LANES * LANE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    packed_lane_assembler_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    packed_lane_assembler #(
        .LANES   (LANES),
        .LANE_W  (LANE_W),
        .SEL_BIT (SEL_BIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: lanes of the word in progress, plus the presented word.
    int              cur_q[$];
    logic [WORD_W-1:0] m_word  = '0;
    bit              m_valid = 1'b0;
    bit              m_short = 1'b0;

    int errors     = 0;
    int checks     = 0;
    int valid_seen = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int d, input bit l, input bit ordy);
        bit acc;
        if (r) begin
            cur_q.delete();
            m_valid = 1'b0;
            m_short = 1'b0;
            m_word  = '0;
            return;
        end
        acc = v && (!m_valid || ordy);
        if (m_valid && ordy) m_valid = 1'b0;
        if (acc) begin
            cur_q.push_back(d);
            if (cur_q.size() == LANES || l) begin
                m_word = '0;
                foreach (cur_q[k]) m_word = m_word | WORD_W'(cur_q[k] << (k * LANE_W));
                m_short = (cur_q.size() < LANES);
                m_valid = 1'b1;
                cur_q.delete();
            end
        end
    endtask

    // Apply inputs for one cycle, check the model at negedge, advance model at posedge.
    task automatic drive_cycle(input bit r, input bit v, input logic [LANE_W-1:0] d,
                               input bit l, input bit ordy);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
        @(negedge clk);
        check_value("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
        check_value("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            check_value("out_word", 32'(bus.out_word), 32'(m_word));
            check_value("out_sel", 32'(bus.out_sel), 32'(m_word[SEL_BIT]));
            check_value("out_short", 32'(bus.out_short), 32'(m_short));
        end
        if (bus.out_valid === 1'b1) valid_seen++;
        @(posedge clk);
        model_step(r, v, int'(d), l, ordy);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        drive_cycle(1, 0, 2'b00, 0, 1);
        drive_cycle(1, 0, 2'b00, 0, 1);
        check_value("rst_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_word", 32'(bus.out_word), 32'd0);
        check_value("rst_short", 32'(bus.out_short), 32'd0);
        check_value("rst_ready", 32'(bus.in_ready), 32'd1);

        // Full word 01,10,11; out_valid only after the third accept
        drive_cycle(0, 1, 2'b01, 0, 1);
        drive_cycle(0, 1, 2'b10, 0, 1);
        check_value("t1_latency", 32'(bus.out_valid), 32'd0);
        drive_cycle(0, 1, 2'b11, 0, 1);
        check_value("t1_valid", 32'(bus.out_valid), 32'd1);
        check_value("t1_word", 32'(bus.out_word), 32'b111001);
        check_value("t1_sel", 32'(bus.out_sel), 32'd0);
        check_value("t1_short", 32'(bus.out_short), 32'd0);

        // Lanes 10,00,00 with the first taken on handoff
        drive_cycle(0, 1, 2'b10, 0, 1);
        drive_cycle(0, 1, 2'b00, 0, 1);
        drive_cycle(0, 1, 2'b00, 0, 1);
        check_value("t2_word", 32'(bus.out_word), 32'b000010);
        check_value("t2_sel", 32'(bus.out_sel), 32'd1);

        // Single lane with in_last, closed straight back into HOLD
        drive_cycle(0, 1, 2'b11, 1, 1);
        check_value("t3_valid", 32'(bus.out_valid), 32'd1);
        check_value("t3_word", 32'(bus.out_word), 32'b000011);
        check_value("t3_short", 32'(bus.out_short), 32'd1);
        check_value("t3_sel", 32'(bus.out_sel), 32'd1);

        // Backpressure: word held, new lane waits
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 2'b01, 0, 0);
            check_value("t4_hold_word", 32'(bus.out_word), 32'b000011);
            check_value("t4_hold_rdy", 32'(bus.in_ready), 32'd0);
        end
        drive_cycle(0, 1, 2'b01, 0, 1);
        check_value("t4_handoff_valid", 32'(bus.out_valid), 32'd0);
        check_value("t4_lane0", 32'(bus.out_word), 32'b000001);
        drive_cycle(0, 1, 2'b10, 0, 1);
        drive_cycle(0, 1, 2'b11, 0, 1);
        check_value("t4_word", 32'(bus.out_word), 32'b111001);

        // Continuous stream of 9 lanes
        drive_cycle(1, 0, 2'b00, 0, 1);
        valid_seen = 0;
        for (int i = 0; i < 9; i++) drive_cycle(0, 1, LANE_W'($urandom), 0, 1);
        drive_cycle(0, 0, 2'b00, 0, 1);
        check_value("t5_words", 32'(valid_seen), 32'd3);

        // Reset mid-frame and during HOLD
        drive_cycle(0, 1, 2'b11, 0, 1);
        drive_cycle(0, 1, 2'b11, 0, 1);
        drive_cycle(1, 0, 2'b00, 0, 1);
        check_value("t6_rst_word", 32'(bus.out_word), 32'd0);
        drive_cycle(0, 1, 2'b01, 0, 1);
        drive_cycle(0, 1, 2'b00, 0, 1);
        drive_cycle(0, 1, 2'b10, 0, 0);
        check_value("t6_fresh_word", 32'(bus.out_word), 32'b100001);
        check_value("t6_fresh_short", 32'(bus.out_short), 32'd0);
        drive_cycle(0, 0, 2'b00, 0, 0);
        drive_cycle(1, 0, 2'b00, 0, 0);
        check_value("t6_hold_rst_valid", 32'(bus.out_valid), 32'd0);
        check_value("t6_hold_rst_word", 32'(bus.out_word), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 59) == 0),
                        ($urandom_range(0, 3) != 0),
                        LANE_W'($urandom),
                        ($urandom_range(0, 4) == 0),
                        ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_packed_lane_assembler
`default_nettype wire
